gpu_div_seq: RTL and testbench



---
 rtl/gpu_div_pkg.sv | 15 +
 rtl/gpu_div_seq_step.sv | 23 ++
 rtl/gpu_div_seq.sv | 133 +++++++++++++
 tb/tb_gpu_div_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_div_pkg.sv
// Shared definitions for the sequential 32-bit divider: iteration counts,
// FSM state encoding and the iteration counter type.
package gpu_div_pkg;

    localparam int DIV_INT_ITER  = 32;
    localparam int DIV_FRAC_ITER = 48;

    typedef enum logic {
        DIV_IDLE,
        DIV_RUN
    } div_state_e;

    typedef logic [5:0] div_cnt_t;

endpackage

// File: rtl/gpu_div_seq_step.sv
// One restoring division step: T = {P, next dividend bit}, subtract the divisor
// when it fits and report the quotient bit as the subtractor's carry-out.
module div_step (
    input  logic [31:0] p_i,
    input  logic        bit_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] p_o,
    output logic        qbit_o
);

    logic [32:0] t;
    logic [31:0] diff;
    logic        carry;

    assign t = {p_i, bit_i};

    // 33-bit T + ~{0,divisor} + 1, split at bit 32: T's top bit can only add to
    // the carry, and whenever the subtraction is kept the difference is < divisor.
    assign {carry, diff} = {1'b0, t[31:0]} + {1'b0, ~divisor_i} + 33'd1;
    assign qbit_o        = t[32] | carry;
    assign p_o           = qbit_o ? diff : t[31:0];

endmodule

// File: rtl/gpu_div_seq.sv
// Sequential unsigned 32-bit divider (integer and 16.16 fractional modes),
// one restoring step per clock behind a start/done handshake.
module gpu_div_seq
    import gpu_div_pkg::*;
#(
    parameter int FRAC_SHIFT = 16
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frac,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        dz,
    output logic        ovf
);

    localparam div_cnt_t INT_LAST  = div_cnt_t'(DIV_INT_ITER - 1);
    localparam div_cnt_t FRAC_LAST = div_cnt_t'(DIV_FRAC_ITER - 1);

    div_state_e  state_q, state_d;
    div_cnt_t    cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    // P never reaches the divisor after a step, so 32 bits always hold it.
    logic [31:0] p_q, p_d;
    logic [47:0] d_q, d_d;
    logic [47:0] q_q, q_d;
    logic [31:0] div_q, div_d;

    logic [31:0] step_p;
    logic        step_qbit;
    logic [47:0] q_shift;

    div_step u_step (
        .p_i      (p_q),
        .bit_i    (d_q[47]),
        .divisor_i(div_q),
        .p_o      (step_p),
        .qbit_o   (step_qbit)
    );

    assign q_shift = {q_q[46:0], step_qbit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        p_d     = p_q;
        d_d     = d_q;
        q_d     = q_q;
        div_d   = div_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    p_d     = '0;
                    // Dividend is left-justified so the first consumed bit is always d_q[47].
                    d_d     = frac ? ({16'h0, dividend} << FRAC_SHIFT) : {dividend, 16'h0};
                    q_d     = '0;
                    div_d   = divisor;
                    cnt_d   = frac ? FRAC_LAST : INT_LAST;
                    quot_d  = '0;
                    rem_d   = '0;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DIV_RUN;
                end
            end
            DIV_RUN: begin
                p_d   = step_p;
                d_d   = {d_q[46:0], 1'b0};
                q_d   = q_shift;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == '0) begin
                    state_d = DIV_IDLE;
                    done_d  = 1'b1;
                    quot_d  = q_shift[31:0];
                    rem_d   = step_p;
                    ovf_d   = |q_shift[47:32];
                    dz_d    = (div_q == '0);
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        p_q   <= p_d;
        d_q   <= d_d;
        q_q   <= q_d;
        div_q <= div_d;
    end

    assign busy      = (state_q == DIV_RUN);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_gpu_div_seq.sv
// Self-checking bench for gpu_div_seq: directed table, handshake corner cases
// and random operands against an arithmetic reference model.
module tb_gpu_div_seq;

    localparam int FRAC_SHIFT = 16;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic        frac    = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor  = '0;
    logic        busy, done, dz, ovf;
    logic [31:0] quotient, remainder;

    int checks   = 0;
    int failures = 0;

    gpu_div_seq #(.FRAC_SHIFT(FRAC_SHIFT)) dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .start    (start),
        .frac     (frac),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .dz       (dz),
        .ovf      (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit          f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        bit          dz;
        bit          ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input bit f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output bit mdz, output bit movf);
        logic [63:0] num, qq;
        num = f ? ({32'h0, a} << FRAC_SHIFT) : {32'h0, a};
        if (b == 32'h0) begin
            q    = 32'hFFFF_FFFF;
            r    = f ? {a[15:0], 16'h0} : a;
            mdz  = 1'b1;
            movf = f;
        end else begin
            qq   = num / {32'h0, b};
            q    = qq[31:0];
            r    = 32'(num % {32'h0, b});
            mdz  = 1'b0;
            movf = |qq[63:32];
        end
    endfunction

    // Called at a negedge; start is seen by the next posedge, returns in cycle 1.
    task automatic launch(input bit f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; frac = f; dividend = a; divisor = b;
        @(negedge sys_clk);
        start = 1'b0; frac = $urandom_range(0, 1); dividend = $urandom; divisor = $urandom;
    endtask

    // Counts cycles until done; busy must stay high until then and low with done.
    task automatic wait_done(input int first, output int lat, output bit busy_ok);
        lat = first;
        busy_ok = 1'b1;
        while (!done && lat < 80) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge sys_clk);
            lat++;
        end
        if (!done) lat = -1;
        if (busy) busy_ok = 1'b0;
    endtask

    task automatic check_result(input string tag, input bit f, input logic [31:0] a,
                                input logic [31:0] b, input int lat, input bit busy_ok);
        logic [31:0] eq, er;
        bit edz, eovf;
        model(f, a, b, eq, er, edz, eovf);
        chk({tag, " latency"}, 32'(lat), f ? 32'd49 : 32'd33);
        chk({tag, " busy"}, {31'h0, busy_ok}, 32'd1);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " dz"}, {31'h0, dz}, {31'h0, edz});
        chk({tag, " ovf"}, {31'h0, ovf}, {31'h0, eovf});
    endtask

    vec_t tbl[4];

    initial begin
        int lat;
        bit bok;
        logic [31:0] ra, rb;
        bit rf;

        tbl[0] = '{f: 1'b0, a: 32'd100,        b: 32'd7, q: 32'd14,        r: 32'd2,        dz: 1'b0, ovf: 1'b0};
        tbl[1] = '{f: 1'b1, a: 32'd1,          b: 32'd2, q: 32'h0000_8000, r: 32'd0,        dz: 1'b0, ovf: 1'b0};
        tbl[2] = '{f: 1'b0, a: 32'h1234_5678,  b: 32'd0, q: 32'hFFFF_FFFF, r: 32'h1234_5678, dz: 1'b1, ovf: 1'b0};
        tbl[3] = '{f: 1'b1, a: 32'h0002_0000,  b: 32'd1, q: 32'h0000_0000, r: 32'd0,        dz: 1'b0, ovf: 1'b1};

        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        chk("reset busy", {31'h0, busy}, 32'd0);
        chk("reset done", {31'h0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset dz_ovf", {30'h0, dz, ovf}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            launch(tbl[i].f, tbl[i].a, tbl[i].b);
            wait_done(1, lat, bok);
            chk("table latency", 32'(lat), tbl[i].f ? 32'd49 : 32'd33);
            chk("table busy", {31'h0, bok}, 32'd1);
            chk("table quotient", quotient, tbl[i].q);
            chk("table remainder", remainder, tbl[i].r);
            chk("table dz", {31'h0, dz}, {31'h0, tbl[i].dz});
            chk("table ovf", {31'h0, ovf}, {31'h0, tbl[i].ovf});
            @(negedge sys_clk);
            chk("done pulse width", {31'h0, done}, 32'd0);
            chk("result hold", quotient, tbl[i].q);
        end

        // start mid-run with other operands must be ignored
        launch(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge sys_clk);
        start = 1'b1; frac = 1'b1; dividend = 32'd999; divisor = 32'd3;
        @(negedge sys_clk);
        start = 1'b0;
        wait_done(6, lat, bok);
        check_result("midstart", 1'b0, 32'd100, 32'd7, lat, bok);

        // start in the done cycle is accepted
        launch(1'b0, 32'd1000, 32'd10);
        chk("b2b done drop", {31'h0, done}, 32'd0);
        chk("b2b busy rise", {31'h0, busy}, 32'd1);
        chk("b2b cleared", quotient, 32'd0);
        wait_done(1, lat, bok);
        check_result("b2b", 1'b0, 32'd1000, 32'd10, lat, bok);

        // reset at cycle 10 of a run aborts with no done
        launch(1'b0, 32'hDEAD_BEEF, 32'd3);
        repeat (9) @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        chk("abort busy", {31'h0, busy}, 32'd0);
        chk("abort done", {31'h0, done}, 32'd0);
        chk("abort quotient", quotient, 32'd0);
        chk("abort remainder", remainder, 32'd0);
        bok = 1'b1;
        repeat (40) begin
            if (done || busy) bok = 1'b0;
            @(negedge sys_clk);
        end
        chk("abort quiet", {31'h0, bok}, 32'd1);
        launch(1'b1, 32'd3, 32'd4);
        wait_done(1, lat, bok);
        check_result("after abort", 1'b1, 32'd3, 32'd4, lat, bok);

        // reset and start together: reset wins
        reset = 1'b1; start = 1'b1; dividend = 32'd5; divisor = 32'd1;
        @(negedge sys_clk);
        reset = 1'b0; start = 1'b0;
        chk("reset beats start", {31'h0, busy}, 32'd0);

        for (int n = 0; n < 24; n++) begin
            rf = $urandom_range(0, 1);
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1, 2:    rb = $urandom_range(1, 255);
                3:       rb = 32'd1 << $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (rb == 32'd0 && $urandom_range(0, 1) == 0) rb = 32'd1;
            launch(rf, ra, rb);
            wait_done(1, lat, bok);
            check_result("random", rf, ra, rb, lat, bok);
            repeat ($urandom_range(0, 2)) @(negedge sys_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
